// File: rtl/ram_block_mover.sv
// Command-driven FILL / COPY / CHECK initiator for a single-port RAM with combinational read.
// The mem_* outputs are flops loaded from next-state logic, so nothing on the command inputs reaches them combinationally.
module ram_block_mover #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   mism_cnt,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  input  logic [DW-1:0] mem_out
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CRD, S_CWR, S_CHK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [AW:0]   len_q, len_d, i_q, i_d, mism_q, mism_d;
  logic [DW-1:0] pat_q, pat_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [AW-1:0] mem_add_q, mem_add_d;
  logic [DW-1:0] mem_in_q, mem_in_d;
  logic          mem_load_q, mem_load_d;
  logic [AW:0]   i_nx;
  logic          last;

  // i counts words already completed; last means the word now finishing is the final one.
  assign i_nx = i_q + (AW+1)'(1);
  assign last = (i_nx == len_q);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    pat_d      = pat_q;
    i_d        = i_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    mism_d     = mism_q;
    mem_add_d  = '0;
    mem_in_d   = '0;
    mem_load_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src;
          dst_d  = dst;
          len_d  = len;
          pat_d  = pattern;
          i_d    = '0;
          err_d  = 1'b0;
          mism_d = '0;
          if (len == '0 || op == 2'b11) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = (op == 2'b11);
          end else begin
            busy_d = 1'b1;
            case (op)
              2'b00: begin
                state_d    = S_FILL;
                mem_add_d  = dst;
                mem_in_d   = pattern;
                mem_load_d = 1'b1;
              end
              2'b01: begin
                state_d   = S_CRD;
                mem_add_d = src;
              end
              default: begin
                state_d   = S_CHK;
                mem_add_d = dst;
              end
            endcase
          end
        end
      end
      S_FILL: begin
        i_d = i_nx;
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          mem_add_d  = dst_q + i_nx[AW-1:0];
          mem_in_d   = pat_q;
          mem_load_d = 1'b1;
        end
      end
      S_CRD: begin
        // The write-data flop doubles as the copy buffer.
        state_d    = S_CWR;
        mem_add_d  = dst_q + i_q[AW-1:0];
        mem_in_d   = mem_out;
        mem_load_d = 1'b1;
      end
      S_CWR: begin
        i_d = i_nx;
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = S_CRD;
          mem_add_d = src_q + i_nx[AW-1:0];
        end
      end
      S_CHK: begin
        if (mem_out != pat_q) mism_d = mism_q + (AW+1)'(1);
        i_d = i_nx;
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          mem_add_d = dst_q + i_nx[AW-1:0];
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      pat_q      <= '0;
      i_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mism_q     <= '0;
      mem_add_q  <= '0;
      mem_in_q   <= '0;
      mem_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      pat_q      <= pat_d;
      i_q        <= i_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mism_q     <= mism_d;
      mem_add_q  <= mem_add_d;
      mem_in_q   <= mem_in_d;
      mem_load_q <= mem_load_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mism_cnt = mism_q;
  assign mem_add  = mem_add_q;
  assign mem_in   = mem_in_q;
  assign mem_load = mem_load_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: a behavioural RAM plus table-driven commands and a few hand-written corner sequences.
module tb_ram_block_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [13:0] src, dst;
  logic [14:0] len;
  logic [15:0] pattern;
  logic        busy, done, err, mem_load;
  logic [14:0] mism_cnt;
  logic [13:0] mem_add;
  logic [15:0] mem_in, mem_out;

  logic [15:0] ram [0:16383];
  logic        clr_en, poke_en;
  logic [13:0] poke_addr;
  logic [15:0] poke_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_block_mover #(.AW(14), .DW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .pattern(pattern), .busy(busy), .done(done), .err(err),
    .mism_cnt(mism_cnt), .mem_add(mem_add), .mem_in(mem_in),
    .mem_load(mem_load), .mem_out(mem_out)
  );

  assign mem_out = ram[mem_add];

  always @(posedge clk) begin
    if (clr_en) begin
      for (int k = 0; k < 16384; k++) ram[k] <= 16'h0000;
    end else if (poke_en) begin
      ram[poke_addr] <= poke_dat;
    end else if (mem_load) begin
      ram[mem_add] <= mem_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_dat = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one command and counts cycles (cycle 1 follows the accepting edge) until done.
  // stray_at > 0 raises a second FILL start (dst 3000) during that cycle.
  task automatic run_cmd(input logic [1:0] c_op, input logic [13:0] c_src, input logic [13:0] c_dst,
                         input logic [14:0] c_len, input logic [15:0] c_pat, input int stray_at,
                         output int cyc, output int loads);
    @(negedge clk);
    start = 1'b1; op = c_op; src = c_src; dst = c_dst; len = c_len; pattern = c_pat;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    loads = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (mem_load) loads++;
      if (cyc == stray_at) begin
        start = 1'b1; op = 2'b00; dst = 14'd3000; len = 15'd2; pattern = 16'h2222;
      end
      if (done) begin
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        break;
      end
      if (cyc >= 40000) begin
        chk("done_timeout", 32'd1, 32'd0);
        break;
      end
    end
    if (start) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [13:0] src;
    logic [13:0] dst;
    logic [14:0] len;
    logic [15:0] pat;
    int          cyc;
    int          loads;
    logic        err;
    logic [14:0] mism;
  } vec_t;

  vec_t vec [8];

  initial begin
    int cyc, loads;

    vec[0] = '{2'd0, 14'd0,   14'd100,   15'd4, 16'h00AB, 5, 4, 1'b0, 15'd0};
    vec[1] = '{2'd1, 14'd100, 14'd200,   15'd4, 16'h0000, 9, 4, 1'b0, 15'd0};
    vec[2] = '{2'd2, 14'd0,   14'd200,   15'd4, 16'h00AB, 5, 0, 1'b0, 15'd0};
    vec[3] = '{2'd0, 14'd0,   14'd16382, 15'd4, 16'h5555, 5, 4, 1'b0, 15'd0};
    vec[4] = '{2'd3, 14'd0,   14'd400,   15'd4, 16'h9999, 1, 0, 1'b1, 15'd0};
    vec[5] = '{2'd0, 14'd0,   14'd300,   15'd0, 16'h7777, 1, 0, 1'b0, 15'd0};
    vec[6] = '{2'd2, 14'd0,   14'd16382, 15'd4, 16'h5555, 5, 0, 1'b0, 15'd0};
    vec[7] = '{2'd2, 14'd0,   14'd0,     15'd3, 16'h5555, 4, 0, 1'b0, 15'd1};

    reset = 1'b1; start = 1'b0; op = '0; src = '0; dst = '0; len = '0; pattern = '0;
    clr_en = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mism", {17'd0, mism_cnt}, 32'd0);
    chk("rst_load", {31'd0, mem_load}, 32'd0);
    chk("rst_add", {18'd0, mem_add}, 32'd0);
    @(negedge clk);
    clr_en = 1'b0;
    reset = 1'b0;

    for (int n = 0; n < 8; n++) begin
      run_cmd(vec[n].op, vec[n].src, vec[n].dst, vec[n].len, vec[n].pat, 0, cyc, loads);
      chk($sformatf("v%0d_cycles", n), cyc, vec[n].cyc);
      chk($sformatf("v%0d_loads", n), loads, vec[n].loads);
      chk($sformatf("v%0d_err", n), {31'd0, err}, {31'd0, vec[n].err});
      chk($sformatf("v%0d_mism", n), {17'd0, mism_cnt}, {17'd0, vec[n].mism});
    end

    @(negedge clk);
    chk("ram_103", {16'd0, ram[103]}, 32'h00AB);
    chk("ram_104", {16'd0, ram[104]}, 32'h0000);
    chk("ram_200", {16'd0, ram[200]}, 32'h00AB);
    chk("ram_203", {16'd0, ram[203]}, 32'h00AB);
    chk("ram_16383", {16'd0, ram[16383]}, 32'h5555);
    chk("ram_1", {16'd0, ram[1]}, 32'h5555);
    chk("ram_2", {16'd0, ram[2]}, 32'h0000);
    chk("ram_300", {16'd0, ram[300]}, 32'h0000);
    chk("ram_400", {16'd0, ram[400]}, 32'h0000);

    // Single corrupted word, then mism_cnt must hold after done.
    poke(14'd202, 16'h1234);
    run_cmd(2'd2, 14'd0, 14'd200, 15'd4, 16'h00AB, 0, cyc, loads);
    chk("poke_mism", {17'd0, mism_cnt}, 32'd1);
    repeat (3) @(negedge clk);
    chk("mism_held", {17'd0, mism_cnt}, 32'd1);

    // Overlapping forward copy smears the first word upward.
    poke(14'd500, 16'h0001);
    poke(14'd501, 16'h0002);
    poke(14'd502, 16'h0003);
    poke(14'd503, 16'h0004);
    run_cmd(2'd1, 14'd500, 14'd501, 15'd3, 16'h0000, 0, cyc, loads);
    chk("ovl_cycles", cyc, 7);
    chk("ovl_502", {16'd0, ram[502]}, 32'h0001);
    chk("ovl_503", {16'd0, ram[503]}, 32'h0001);

    // Start while busy is ignored.
    run_cmd(2'd0, 14'd0, 14'd2000, 15'd4, 16'h1111, 2, cyc, loads);
    chk("bz_cycles", cyc, 5);
    chk("bz_2003", {16'd0, ram[2003]}, 32'h1111);
    repeat (3) @(negedge clk);
    chk("bz_idle", {31'd0, busy}, 32'd0);
    chk("bz_3000", {16'd0, ram[3000]}, 32'h0000);

    // Start during the DONE cycle is ignored.
    run_cmd(2'd0, 14'd0, 14'd4000, 15'd2, 16'h4444, 3, cyc, loads);
    chk("dn_cycles", cyc, 3);
    @(negedge clk);
    chk("dn_busy", {31'd0, busy}, 32'd0);
    chk("dn_done", {31'd0, done}, 32'd0);
    chk("dn_3000", {16'd0, ram[3000]}, 32'h0000);

    // Reset after two FILL words have been written.
    @(negedge clk);
    start = 1'b1; op = 2'd0; dst = 14'd1000; len = 15'd8; pattern = 16'h7777;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("ar_load", {31'd0, mem_load}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_add", {18'd0, mem_add}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("ar_1001", {16'd0, ram[1001]}, 32'h7777);
    chk("ar_1002", {16'd0, ram[1002]}, 32'h0000);
    run_cmd(2'd2, 14'd0, 14'd1000, 15'd2, 16'h7777, 0, cyc, loads);
    chk("ar_restart_cycles", cyc, 3);
    chk("ar_restart_mism", {17'd0, mism_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
